// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the decode-stage hazard/forwarding unit: select and state encodings,
// the shadow-pipe entry and the register-match helpers used by the forwarding compare.
package pipe_hazard_pkg;

  // Widest supported register index; narrower indices are zero-extended into entries.
  localparam int HZ_RG_W = 8;
  localparam logic [2:0] CNT_ZERO = 3'd0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXM = 2'b01,
    FWD_MWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic [HZ_RG_W-1:0] rg;
    logic               we;
    logic               load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_EMPTY = '{rg: '0, we: 1'b0, load: 1'b0};

  function automatic logic hits(input logic used, input logic [HZ_RG_W-1:0] src,
                                input shadow_entry_t e);
    return used & e.we & (e.rg == src);
  endfunction

  // The nearest in-flight producer wins.
  function automatic fwd_sel_t fwd_pick(input logic used, input logic [HZ_RG_W-1:0] src,
                                        input shadow_entry_t ex, input shadow_entry_t mem);
    fwd_sel_t sel;
    if (hits(used, src, ex)) begin
      sel = FWD_EXM;
    end else if (hits(used, src, mem)) begin
      sel = FWD_MWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-side bundle between the decode stage and the hazard unit.
interface hazard_forward_unit_if #(parameter int REG_W = 4);
  import pipe_hazard_pkg::*;

  logic             dec_valid;
  logic [REG_W-1:0] dec_rp;
  logic [REG_W-1:0] dec_rs;
  logic             dec_use_rp;
  logic             dec_use_rs;
  logic [REG_W-1:0] dec_rg;
  logic             dec_we_reg;
  logic             dec_is_load;
  logic             exe_branch_tkn;
  fwd_sel_t         sel_op_a;
  fwd_sel_t         sel_op_b;
  logic             stall_if_id;
  logic             bubble_ex;
  logic             flush_if_id;
  logic             busy;

  modport master (
    output dec_valid, dec_rp, dec_rs, dec_use_rp, dec_use_rs, dec_rg, dec_we_reg,
           dec_is_load, exe_branch_tkn,
    input  sel_op_a, sel_op_b, stall_if_id, bubble_ex, flush_if_id, busy
  );

  modport slave (
    input  dec_valid, dec_rp, dec_rs, dec_use_rp, dec_use_rs, dec_rg, dec_we_reg,
           dec_is_load, exe_branch_tkn,
    output sel_op_a, sel_op_b, stall_if_id, bubble_ex, flush_if_id, busy
  );
endinterface

// File: rtl/hazard_forward_unit_shadow.sv
// dest_shadow_pipe: mirrors the destination fields of instructions in EXE/MEM/WB.
// A non-issued decode slot enters EX as an empty entry.
module dest_shadow_pipe
  import pipe_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  shadow_entry_t dec_entry,
  output shadow_entry_t ex_r,
  output shadow_entry_t mem_r,
  output shadow_entry_t wb_r
);

  // Advance the shadow entries every cycle, inserting an empty entry on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r  <= SHADOW_EMPTY;
      mem_r <= SHADOW_EMPTY;
      wb_r  <= SHADOW_EMPTY;
    end else begin
      ex_r  <= issue ? dec_entry : SHADOW_EMPTY;
      mem_r <= ex_r;
      wb_r  <= mem_r;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: operand forwarding selects, load-use stall and taken-branch flush.
// Build macro HAZARD_PERF_CNT_EN adds the stall_cnt/flush_cnt performance counters.
module hazard_forward_unit
  import pipe_hazard_pkg::*;
#(
  parameter int REG_W          = 4,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic        clk,
  input  logic        rst,
  hazard_forward_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [2:0] PENALTY_RELOAD = 3'(BRANCH_PENALTY - 1);

  hz_state_t          state_r, state_nxt_s;
  logic [2:0]         cnt_r, cnt_nxt_s;
  shadow_entry_t      ex_r, mem_r, wb_r, dec_entry_s;
  logic [HZ_RG_W-1:0] rp_s, rs_s;
  logic               use_a_s, use_b_s, load_use_s;
  logic               flushing_s, flush_s, stall_s, bubble_s, issue_s;
  fwd_sel_t           fwd_a_s, fwd_b_s;
  logic               unused_shadow_s;

  assign rp_s    = HZ_RG_W'(hz.dec_rp);
  assign rs_s    = HZ_RG_W'(hz.dec_rs);
  assign use_a_s = hz.dec_valid & hz.dec_use_rp;
  assign use_b_s = hz.dec_valid & hz.dec_use_rs;
  assign fwd_a_s = fwd_pick(use_a_s, rp_s, ex_r, mem_r);
  assign fwd_b_s = fwd_pick(use_b_s, rs_s, ex_r, mem_r);

  // A load in EX has no result yet, so a consumer right behind it must wait one cycle.
  assign load_use_s = ex_r.load & (hits(use_a_s, rp_s, ex_r) | hits(use_b_s, rs_s, ex_r));
  assign flushing_s = (state_r == FLUSH) && (cnt_r != CNT_ZERO);
  assign flush_s    = hz.exe_branch_tkn | flushing_s;
  assign stall_s    = load_use_s & ~flush_s;
  assign bubble_s   = flush_s | stall_s;
  assign issue_s    = hz.dec_valid & ~bubble_s;

  assign dec_entry_s = '{rg: HZ_RG_W'(hz.dec_rg), we: hz.dec_we_reg, load: hz.dec_is_load};

  // WB and the MEM load flag are tracked for completeness but never steer forwarding.
  assign unused_shadow_s = ^{wb_r, mem_r.load};

  dest_shadow_pipe u_shadow (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue_s),
    .dec_entry (dec_entry_s),
    .ex_r      (ex_r),
    .mem_r     (mem_r),
    .wb_r      (wb_r)
  );

  // Pipeline-control outputs; selects are squashed whenever a bubble enters EXE.
  always_comb begin
    hz.sel_op_a    = FWD_RF;
    hz.sel_op_b    = FWD_RF;
    if (bubble_s) begin
      hz.sel_op_a = FWD_RF;
      hz.sel_op_b = FWD_RF;
    end else begin
      hz.sel_op_a = fwd_a_s;
      hz.sel_op_b = fwd_b_s;
    end
    hz.stall_if_id = stall_s;
    hz.bubble_ex   = bubble_s;
    hz.flush_if_id = flush_s;
    hz.busy        = (state_r != RUN);
  end

  // Next state and penalty count; a taken branch wins and restarts the flush window.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (hz.exe_branch_tkn) begin
      if (BRANCH_PENALTY > 1) begin
        state_nxt_s = FLUSH;
        cnt_nxt_s   = PENALTY_RELOAD;
      end else begin
        state_nxt_s = RUN;
        cnt_nxt_s   = CNT_ZERO;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (stall_s) begin
            state_nxt_s = LDSTALL;
          end else begin
            state_nxt_s = RUN;
          end
        end
        LDSTALL: begin
          state_nxt_s = RUN;
        end
        FLUSH: begin
          if (cnt_r <= 3'd1) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s   = cnt_r - 3'd1;
          end
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and penalty-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Count stalled and flushed cycles; both wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, stall_s};
      flush_cnt <= flush_cnt + {31'd0, flush_s};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios plus a randomized
// run compared against an instruction-history reference model.
module tb_hazard_forward_unit;
  import pipe_hazard_pkg::*;

  localparam int REG_W = 4;
  localparam int BP    = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_forward_unit_if #(.REG_W(REG_W)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_forward_unit #(.REG_W(REG_W), .BRANCH_PENALTY(BP)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: destinations of the last two issued slots (0 = in EXE, 1 = in MEM),
  // remaining flush cycles after a taken branch, and the expected busy flag.
  logic [REG_W-1:0] m_rg [2];
  logic             m_we [2];
  logic             m_ld [2];
  int               m_flush_left;
  logic             m_busy;
  logic             m_busy_known;

  function automatic logic [1:0] exp_fwd(input logic used, input logic [REG_W-1:0] src);
    if (!(hz.dec_valid && used)) return 2'b00;
    if (m_we[0] && m_rg[0] == src) return 2'b01;
    if (m_we[1] && m_rg[1] == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_flush();
    return hz.exe_branch_tkn || (m_flush_left > 0);
  endfunction

  function automatic logic exp_stall();
    logic lu;
    lu = hz.dec_valid && m_ld[0] && m_we[0] &&
         ((hz.dec_use_rp && hz.dec_rp == m_rg[0]) || (hz.dec_use_rs && hz.dec_rs == m_rg[0]));
    return lu && !exp_flush();
  endfunction

  function automatic logic exp_bubble();
    return exp_flush() || exp_stall();
  endfunction

  function automatic logic [7:0] exp_outs();
    logic [1:0] a, b;
    a = exp_bubble() ? 2'b00 : exp_fwd(hz.dec_use_rp, hz.dec_rp);
    b = exp_bubble() ? 2'b00 : exp_fwd(hz.dec_use_rs, hz.dec_rs);
    return {a, b, exp_stall(), exp_bubble(), exp_flush(), m_busy};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_rg[0] <= '0; m_we[0] <= 1'b0; m_ld[0] <= 1'b0;
      m_rg[1] <= '0; m_we[1] <= 1'b0; m_ld[1] <= 1'b0;
      m_flush_left <= 0;
      m_busy       <= 1'b0;
      m_busy_known <= 1'b1;
    end else begin
      if (hz.dec_valid && !exp_bubble()) begin
        m_rg[0] <= hz.dec_rg; m_we[0] <= hz.dec_we_reg; m_ld[0] <= hz.dec_is_load;
      end else begin
        m_rg[0] <= '0; m_we[0] <= 1'b0; m_ld[0] <= 1'b0;
      end
      m_rg[1] <= m_rg[0]; m_we[1] <= m_we[0]; m_ld[1] <= m_ld[0];
      if (hz.exe_branch_tkn) m_flush_left <= BP - 1;
      else if (m_flush_left > 0) m_flush_left <= m_flush_left - 1;
      else m_flush_left <= 0;
      m_busy       <= hz.exe_branch_tkn ? (BP > 1) : ((m_flush_left > 1) || exp_stall());
      m_busy_known <= !exp_stall();
    end
  end

  function automatic logic [7:0] outs();
    return {hz.sel_op_a, hz.sel_op_b, hz.stall_if_id, hz.bubble_ex, hz.flush_if_id, hz.busy};
  endfunction

  task automatic set_dec(input logic v, input logic [REG_W-1:0] rp, input logic urp,
                         input logic [REG_W-1:0] rs, input logic urs,
                         input logic [REG_W-1:0] rg, input logic we, input logic ld,
                         input logic tkn);
    hz.dec_valid = v;  hz.dec_rp = rp; hz.dec_use_rp = urp;
    hz.dec_rs = rs;    hz.dec_use_rs = urs;
    hz.dec_rg = rg;    hz.dec_we_reg = we; hz.dec_is_load = ld;
    hz.exe_branch_tkn = tkn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    exp = 8'b0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL reset_hold: got %b expected %b", outs(), exp); end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL reset_release: got %b expected %b", outs(), exp); end
  endtask

  task automatic test_fwd_exm();
    logic [7:0] exp;
    idle(3);
    @(negedge clk); set_dec(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0); #1;
    exp = 8'b00_00_0000; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL exm_producer: got %b expected %b", outs(), exp); end
    @(negedge clk); set_dec(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0); #1;
    exp = 8'b01_00_0000; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL exm_consumer_rp: got %b expected %b", outs(), exp); end
  endtask

  task automatic test_fwd_mwb();
    logic [7:0] exp;
    for (int gap = 1; gap <= 2; gap++) begin
      idle(3);
      @(negedge clk); set_dec(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
      idle(gap);
      @(negedge clk); set_dec(1'b1, 4'd7, 1'b1, 4'd3, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0); #1;
      exp = (gap == 1) ? 8'b00_10_0000 : 8'b00_00_0000;
      n_checks++;
      if (outs() !== exp) begin
        n_errors++; $display("FAIL mwb_gap%0d: got %b expected %b", gap, outs(), exp);
      end
    end
  endtask

  task automatic test_load_use();
    logic [7:0] exp;
    idle(3);
    @(negedge clk); set_dec(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    @(negedge clk); set_dec(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0); #1;
    exp = 8'b00_00_1100; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL load_use_stall: got %b expected %b", outs(), exp); end
    @(negedge clk); #1;
    exp = 8'b10_00_0000; n_checks++;
    if ((outs() & 8'hFE) !== exp) begin
      n_errors++; $display("FAIL load_use_resolve: got %b expected %b", outs() & 8'hFE, exp);
    end
    idle(1); #1;
    exp = 8'b00_00_0000; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL load_use_done: got %b expected %b", outs(), exp); end
  endtask

  task automatic test_branch();
    logic [7:0] exp;
    idle(3);
    @(negedge clk); set_dec(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk); set_dec(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1); #1;
    exp = 8'b00_00_0110; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL branch_cycle: got %b expected %b", outs(), exp); end
    idle(1); #1;
    exp = 8'b00_00_0111; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL branch_penalty: got %b expected %b", outs(), exp); end
    idle(1); #1;
    exp = 8'b00_00_0000; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL branch_done: got %b expected %b", outs(), exp); end
    // A second taken branch inside the window restarts it.
    @(negedge clk); set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(1); #1;
    exp = 8'b00_00_0111; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL branch_restart: got %b expected %b", outs(), exp); end
    idle(1); #1;
    exp = 8'b00_00_0000; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL restart_done: got %b expected %b", outs(), exp); end
  endtask

  task automatic test_branch_vs_load();
    logic [7:0] exp;
    idle(3);
    @(negedge clk); set_dec(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    @(negedge clk); set_dec(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1); #1;
    exp = 8'b00_00_0110; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL branch_beats_load: got %b expected %b", outs(), exp); end
    idle(1); #1;
    exp = 8'b00_00_0111; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL flush_not_ldstall: got %b expected %b", outs(), exp); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    exp = 8'b00_00_0000; n_checks++;
    if (outs() !== exp) begin n_errors++; $display("FAIL reset_mid_flush: got %b expected %b", outs(), exp); end
  endtask

  task automatic test_random();
    logic [7:0] exp, mask;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) < 2);
      set_dec($urandom_range(0, 3) != 0,
              REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
              $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 8);
      #1;
      exp  = exp_outs();
      mask = m_busy_known ? 8'hFF : 8'hFE;
      n_checks++;
      if ((outs() & mask) !== (exp & mask)) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got %b expected %b (mask %b)", i, outs(), exp, mask);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk); rst = 1'b1;
    set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_errors++; $display("FAIL perf_clear: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    idle(2);
    @(negedge clk); set_dec(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    @(negedge clk); set_dec(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle(1);
    @(negedge clk); set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(3); #1;
    n_checks++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 32'd2) begin
      n_errors++; $display("FAIL perf_counts: got %0d/%0d expected 1/2", stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_fwd_exm();
    test_fwd_mwb();
    test_load_use();
    test_branch();
    test_branch_vs_load();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
